// File: rtl/onn_pkg.sv
// Shared types and width helpers for the oscillatory neuron array.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package onn_pkg;

  // Default phase width; the array itself is parameterised on PHASE_W.
  localparam int PHASE_W_DEFAULT = 4;
  typedef logic [PHASE_W_DEFAULT-1:0] phase_t;

  // Serial load/readback controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ser_state_t;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/onn_neuron_cell.sv
// One oscillatory neuron: phase register, period snapshot and change flag.
// Latency: phase, snapshot and change flag update one cycle after their enables.
// Backpressure: none; shift has priority over advance, clear over snapshot.
import onn_pkg::*;

module onn_neuron_cell #(
  parameter int PHASE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               advance,
  input  logic               nin,
  input  logic               shift,
  input  logic               shift_in,
  input  logic               snap_take,
  input  logic               snap_clear,
  output logic [PHASE_W-1:0] phi,
  output logic               nout,
  output logic               changed,
  output logic               state_changed
);

  logic [PHASE_W-1:0] snap;

  assign nout    = phi[PHASE_W-1];
  assign changed = (phi != snap);

  // Phase: serial chain shift wins, else advance by 1 (in sync) or 2 (coupling pull).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phi <= '0;
    end else if (shift) begin
      phi <= {shift_in, phi[PHASE_W-1:1]};
    end else if (advance) begin
      phi <= phi + ((nin != nout) ? PHASE_W'(2) : PHASE_W'(1));
    end
  end

  // Snapshot: end-of-transfer clear re-baselines; period strobe records the change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap          <= '0;
      state_changed <= 1'b0;
    end else if (snap_clear) begin
      snap          <= phi;
      state_changed <= 1'b0;
    end else if (snap_take) begin
      snap          <= phi;
      state_changed <= changed;
    end
  end

endmodule

// File: rtl/onn_neuron_array.sv
// ROWS x COLS oscillatory neuron array with serial phase load/readback and convergence flag.
// Latency: phase/flags visible one cycle after tick/full_tick; ser_done one cycle after last shift.
// Backpressure: tick/full_tick ignored while ser_busy; ser_start ignored unless idle.
import onn_pkg::*;

module onn_neuron_array #(
  parameter int ROWS           = 3,
  parameter int COLS           = 5,
  parameter int PHASE_W        = 4,
  parameter int STABLE_PERIODS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        run_en,
  input  logic                        tick,
  input  logic                        full_tick,
  input  logic [ROWS*COLS-1:0]        nin,
  input  logic                        ser_start,
  input  logic                        ser_valid,
  input  logic                        ser_in,
  output logic                        ser_out,
  output logic                        ser_busy,
  output logic                        ser_done,
  output logic [ROWS*COLS-1:0]        nout,
  output logic [ROWS*COLS-1:0]        state_changed,
  output logic [ROWS*COLS*PHASE_W-1:0] phi_out,
  output logic                        converged
);

  localparam int N  = ROWS * COLS;
  localparam int L  = N * PHASE_W;
  localparam int BW = cnt_width(L - 1);
  localparam int SW = cnt_width(STABLE_PERIODS);

  ser_state_t    state;
  logic [BW-1:0] bit_cnt;
  logic [SW-1:0] stable_cnt;
  logic [N-1:0]  changed;
  logic          advance;
  logic          shift;
  logic          snap_take;
  logic          snap_clear;

  // The DONE cycle re-baselines snapshots, so a period strobe there is absorbed.
  assign advance    = run_en & tick & ~ser_busy;
  assign shift      = (state == SHIFT) & ser_valid;
  assign snap_clear = (state == DONE);
  assign snap_take  = full_tick & ~ser_busy & ~snap_clear;
  assign ser_out    = phi_out[PHASE_W*(N-1)];

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_cell
      logic chain_in;
      if (g == 0) begin : g_head
        assign chain_in = ser_in;
      end else begin : g_link
        assign chain_in = phi_out[PHASE_W*(g-1)];
      end
      onn_neuron_cell #(.PHASE_W(PHASE_W)) u_cell (
        .clk           (clk),
        .rst           (rst),
        .advance       (advance),
        .nin           (nin[g]),
        .shift         (shift),
        .shift_in      (chain_in),
        .snap_take     (snap_take),
        .snap_clear    (snap_clear),
        .phi           (phi_out[PHASE_W*g +: PHASE_W]),
        .nout          (nout[g]),
        .changed       (changed[g]),
        .state_changed (state_changed[g])
      );
    end
  endgenerate

  // Serial transfer controller with registered busy/done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      ser_busy <= 1'b0;
      ser_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ser_done <= 1'b0;
          if (ser_start) begin
            state    <= SHIFT;
            bit_cnt  <= '0;
            ser_busy <= 1'b1;
          end
        end
        SHIFT: begin
          if (ser_valid) begin
            if (bit_cnt == BW'(L - 1)) begin
              state    <= DONE;
              ser_busy <= 1'b0;
              ser_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          ser_done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          ser_busy <= 1'b0;
          ser_done <= 1'b0;
        end
      endcase
    end
  end

  // Convergence: count consecutive unchanged periods, saturating at the threshold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_cnt <= '0;
      converged  <= 1'b0;
    end else if (snap_clear) begin
      stable_cnt <= '0;
      converged  <= 1'b0;
    end else if (snap_take) begin
      if (|changed) begin
        stable_cnt <= '0;
        converged  <= 1'b0;
      end else if (stable_cnt != SW'(STABLE_PERIODS)) begin
        stable_cnt <= stable_cnt + SW'(1);
        converged  <= (stable_cnt == SW'(STABLE_PERIODS - 1));
      end
    end
  end

endmodule

// File: tb/tb_onn_neuron_array.sv
// Self-checking bench for onn_neuron_array with a cycle-level reference model and scoreboard.
// Latency: expected outputs are queued at each clock edge and compared on the following falling edge.
// Backpressure: n/a.
module tb_onn_neuron_array;

  localparam int ROWS = 3;
  localparam int COLS = 5;
  localparam int W    = 4;
  localparam int SP   = 4;
  localparam int N    = ROWS * COLS;
  localparam int L    = N * W;

  logic clk = 1'b0;
  logic rst, run_en, tick, full_tick, ser_start, ser_valid, ser_in;
  logic ser_out, ser_busy, ser_done, converged;
  logic [N-1:0] nin, nout, state_changed;
  logic [L-1:0] phi_out;

  always #5 clk = ~clk;

  onn_neuron_array #(.ROWS(ROWS), .COLS(COLS), .PHASE_W(W), .STABLE_PERIODS(SP)) dut (
    .clk(clk), .rst(rst), .run_en(run_en), .tick(tick), .full_tick(full_tick), .nin(nin),
    .ser_start(ser_start), .ser_valid(ser_valid), .ser_in(ser_in), .ser_out(ser_out),
    .ser_busy(ser_busy), .ser_done(ser_done), .nout(nout), .state_changed(state_changed),
    .phi_out(phi_out), .converged(converged)
  );

  typedef struct packed {
    logic [L-1:0] phi;
    logic [N-1:0] nout;
    logic [N-1:0] sc;
    logic         conv;
    logic         busy;
    logic         done;
    logic         sout;
  } exp_t;

  exp_t exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: phases as integers, transfer mode 0=idle 1=loading 2=finishing.
  int m_phi[N];
  int m_snap[N];
  bit m_sc[N];
  int m_cnt;
  int m_mode;
  int m_bits;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_phi[i] = 0; m_snap[i] = 0; m_sc[i] = 0;
    end
    m_cnt = 0; m_mode = 0; m_bits = 0;
  endtask

  function automatic logic [N-1:0] m_nout_vec();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_phi[i][W-1];
    return r;
  endfunction

  task automatic model_step();
    int np[N];
    int ns[N];
    bit nsc[N];
    int ncnt, nmode, nbits;
    bit busy_old, any;
    np = m_phi; ns = m_snap; nsc = m_sc;
    ncnt = m_cnt; nmode = m_mode; nbits = m_bits;
    busy_old = (m_mode == 1);
    if (m_mode == 1 && ser_valid) begin
      for (int i = 0; i < N; i++) begin
        int b;
        b = (i == 0) ? int'(ser_in) : (m_phi[i-1] & 1);
        np[i] = (m_phi[i] >> 1) | (b << (W - 1));
      end
    end else if (run_en && tick && !busy_old) begin
      for (int i = 0; i < N; i++)
        np[i] = (m_phi[i] + ((int'(nin[i]) != int'(m_phi[i][W-1])) ? 2 : 1)) % (1 << W);
    end
    if (m_mode == 2) begin
      ns = m_phi;
      for (int i = 0; i < N; i++) nsc[i] = 0;
      ncnt = 0;
    end else if (full_tick && !busy_old) begin
      any = 0;
      for (int i = 0; i < N; i++) begin
        nsc[i] = (m_phi[i] != m_snap[i]);
        any = any | nsc[i];
      end
      ns = m_phi;
      ncnt = any ? 0 : ((m_cnt < SP) ? m_cnt + 1 : SP);
    end
    case (m_mode)
      0: if (ser_start) begin nmode = 1; nbits = 0; end
      1: if (ser_valid) begin
           nbits = m_bits + 1;
           if (nbits == L) nmode = 2;
         end
      default: nmode = 0;
    endcase
    m_phi = np; m_snap = ns; m_sc = nsc; m_cnt = ncnt; m_mode = nmode; m_bits = nbits;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.phi[W*i +: W] = W'(m_phi[i]);
      e.nout[i]       = m_phi[i][W-1];
      e.sc[i]         = m_sc[i];
    end
    e.conv = (m_cnt == SP);
    e.busy = (m_mode == 1);
    e.done = (m_mode == 2);
    e.sout = m_phi[N-1][0];
    return e;
  endfunction

  function automatic logic [L-1:0] all_phase(input int v);
    logic [L-1:0] r;
    for (int i = 0; i < N; i++) r[W*i +: W] = W'(v);
    return r;
  endfunction

  // One clock: advance the model with the inputs present at the edge and queue the expectation.
  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    exp_q.push_back(model_out());
    #2;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor: every falling edge with a queued expectation compares all outputs.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e, a;
        e = exp_q.pop_front();
        a = {phi_out, nout, state_changed, converged, ser_busy, ser_done, ser_out};
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL cycle_outputs t=%0t phi %h/%h nout %h/%h sc %h/%h conv %b/%b busy %b/%b done %b/%b sout %b/%b (got/expected)",
                      $time, a.phi, e.phi, a.nout, e.nout, a.sc, e.sc, a.conv, e.conv,
                      a.busy, e.busy, a.done, e.done, a.sout, e.sout);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [L-1:0] r, prior, rb, exp_rb;
    int sent;
    bit sent_bits[L];

    rst = 1; run_en = 0; tick = 0; full_tick = 0; nin = '0;
    ser_start = 0; ser_valid = 0; ser_in = 0;
    model_reset();
    cyc(); cyc();
    check("reset_phi", 64'(phi_out), 64'd0);
    check("reset_flags", 64'({nout, state_changed, converged, ser_busy, ser_done}), 64'd0);
    rst = 0;
    cyc();

    // In-sync advance: 8 ticks reach mid-phase, 16 wrap.
    run_en = 1;
    for (int k = 0; k < 16; k++) begin
      nin = m_nout_vec(); tick = 1;
      cyc();
      tick = 0;
      if (k == 7) begin
        check("sync_phi_8", 64'(phi_out), 64'(all_phase(8)));
        check("sync_nout_high", 64'(nout), 64'(15'h7fff));
      end
    end
    check("sync_wrap_0", 64'(phi_out), 64'd0);

    // Coupling speed-up on neuron 3 only.
    for (int k = 0; k < 3; k++) begin
      nin = m_nout_vec() ^ N'(1 << 3); tick = 1;
      cyc();
    end
    tick = 0;
    r = all_phase(3); r[W*3 +: W] = 4'd6;
    check("coupled_phases", 64'(phi_out), 64'(r));
    prior = r;

    // Serial load of a single 1 followed by zeros; capture readback.
    ser_start = 1; cyc(); ser_start = 0;
    for (int k = 0; k < L; k++) begin
      ser_in = (k == 0); ser_valid = 1;
      rb[k] = ser_out;
      cyc();
    end
    ser_valid = 0; ser_in = 0;
    check("load_done_pulse", 64'({ser_done, ser_busy}), 64'b10);
    for (int k = 0; k < L; k++) exp_rb[k] = prior[W*(N-1-k/W) + k%W];
    check("load_readback", 64'(rb), 64'(exp_rb));
    check("load_phases", 64'(phi_out), 64'(L'(1) << (W*(N-1))));
    cyc();
    check("load_done_single", 64'(ser_done), 64'd0);

    // Load with interfering ticks, full_ticks, ser_start and gaps in ser_valid.
    cyc();
    ser_start = 1; cyc(); ser_start = 0;
    sent = 0;
    while (sent < L) begin
      ser_valid = ($urandom_range(0, 3) != 0);
      ser_in = 1'($urandom); tick = 1'($urandom); full_tick = 1'($urandom);
      ser_start = 1'($urandom); nin = N'($urandom); run_en = 1;
      if (ser_valid) begin sent_bits[sent] = ser_in; sent++; end
      cyc();
    end
    ser_valid = 0; tick = 0; full_tick = 0; ser_start = 0;
    check("busy_load_length", 64'(ser_done), 64'd1);
    for (int k = 0; k < L; k++) begin
      int p;
      p = L - 1 - k;
      r[W*(p/W) + (W-1-p%W)] = sent_bits[k];
    end
    check("busy_load_phases", 64'(phi_out), 64'(r));
    cyc();
    check("post_load_flags", 64'({state_changed, converged}), 64'd0);

    // Held phases converge; a single tick breaks it.
    run_en = 0;
    for (int f = 0; f < 4; f++) begin
      full_tick = 1; cyc(); full_tick = 0; cyc();
      if (f == 0) check("hold_no_change", 64'(state_changed), 64'd0);
      if (f == 2) check("hold_not_yet_conv", 64'(converged), 64'd0);
    end
    check("hold_converged", 64'(converged), 64'd1);
    run_en = 1; nin = m_nout_vec(); tick = 1; cyc(); tick = 0;
    full_tick = 1; cyc(); full_tick = 0;
    check("tick_all_changed", 64'(state_changed), 64'(15'h7fff));
    check("tick_conv_cleared", 64'(converged), 64'd0);

    // Random traffic checked against the model every cycle.
    for (int k = 0; k < 400; k++) begin
      run_en = ($urandom_range(0, 3) != 0); tick = 1'($urandom);
      full_tick = ($urandom_range(0, 5) == 0); nin = N'($urandom);
      ser_start = ($urandom_range(0, 40) == 0); ser_valid = 1'($urandom); ser_in = 1'($urandom);
      cyc();
    end
    run_en = 0; tick = 0; full_tick = 0; ser_start = 0; ser_valid = 1;
    for (int k = 0; k < 2 * L && m_mode != 0; k++) cyc();
    ser_valid = 0;
    cyc();
    check("random_drain_idle", 64'({ser_busy, ser_done}), 64'd0);

    // Reset in the middle of a load.
    ser_start = 1; cyc(); ser_start = 0;
    ser_valid = 1;
    for (int k = 0; k < 30; k++) begin ser_in = 1'($urandom); cyc(); end
    ser_valid = 0; ser_in = 0;
    @(negedge clk); #1;
    rst = 1; #1;
    model_reset();
    check("midload_reset_phi", 64'(phi_out), 64'd0);
    check("midload_reset_flags",
          64'({nout, state_changed, converged, ser_busy, ser_done, ser_out}), 64'd0);
    cyc();
    rst = 0;
    cyc(); cyc(); cyc();
    check("midload_no_done", 64'(ser_done), 64'd0);
    ser_start = 1; cyc(); ser_start = 0;
    check("midload_restart", 64'(ser_busy), 64'd1);
    cyc();

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
